// File: rtl/mux_rr_n.sv
// N-input mux with one registered output stage and a valid/ready handshake on
// both sides. A channel is chosen by a fixed select or by a round-robin pointer.
module mux_rr_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        select,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             load;
  logic [WIDTH-1:0] gnt_word;

  assign load = !out_valid || out_ready;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    if (!mode) begin
      // Out-of-range select matches no channel, so it yields no grant.
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (in_valid[i] && select == SEL_W'(i)) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      // Walk offsets from farthest to nearest so the first requester after ptr wins.
      for (int unsigned k = NUM_IN; k >= 1; k--) begin
        for (int unsigned i = 0; i < NUM_IN; i++) begin
          if (in_valid[i] && i == (32'(ptr) + k) % NUM_IN) begin
            gnt_any = 1'b1;
            gnt_idx = SEL_W'(i);
          end
        end
      end
    end
  end

  always_comb begin
    gnt_word = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) gnt_word = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_ready[i] = reset && load && gnt_any && (gnt_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_src   <= '0;
      out_valid <= 1'b0;
      ptr       <= SEL_W'(NUM_IN - 1);
    end else if (load) begin
      if (gnt_any) begin
        out_data  <= gnt_word;
        out_src   <= gnt_idx;
        out_valid <= 1'b1;
        if (mode) ptr <= gnt_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mux_rr_n.md
MUX_RR_N -- requirements
Module: mux_rr_n

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits.
REQ-002 Parameter NUM_IN, default 4, number of input channels, legal range 2..16.
REQ-003 Parameter SEL_W, default 2, width of select and out_src, SHALL satisfy 2**SEL_W >= NUM_IN.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low; clears all state immediately when low.
REQ-006 in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_valid  input  NUM_IN  bit i high means channel i presents a word.
REQ-008 in_ready  output  NUM_IN  bit i high means channel i's word is accepted this cycle.
REQ-009 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-010 select  input  SEL_W  channel index used when mode = 0.
REQ-011 out_data  output  WIDTH  registered output word.
REQ-012 out_valid  output  1  out_data/out_src hold an undelivered word.
REQ-013 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-014 out_src  output  SEL_W  index of the channel that supplied out_data.

Function
REQ-015 Block SHALL contain one output register stage (out_data, out_src, out_valid) and a round-robin pointer ptr (SEL_W bits).
REQ-016 load = (!out_valid || out_ready); evaluated combinationally each cycle.
REQ-017 mode = 0: candidate = select; grant SHALL be issued to candidate iff select < NUM_IN and in_valid[select] = 1.
REQ-018 mode = 0 with select >= NUM_IN: no grant, all in_ready = 0, no word loaded.
REQ-019 mode = 1: grant SHALL go to the first i with in_valid[i] = 1 searching ptr+1, ptr+2, ... modulo NUM_IN, ending at ptr inclusive.
REQ-020 At most one in_ready bit SHALL be high in any cycle; in_ready[i] = load && grant[i] (combinational, no dependence on in_ready).
REQ-021 On a clock edge with load = 1 and a grant to channel g: out_data <= channel g word, out_src <= g, out_valid <= 1.
REQ-022 On a clock edge with load = 1 and no grant: out_valid <= 0; out_data and out_src hold previous values.
REQ-023 On a clock edge with load = 0 (out_valid = 1, out_ready = 0): output register and ptr SHALL hold; all in_ready = 0.
REQ-024 ptr SHALL update to g only on a transfer in mode = 1; transfers in mode = 0 SHALL leave ptr unchanged.
REQ-025 Latency: input word accepted at edge N appears on out_data with out_valid after edge N; throughput one word per cycle with out_ready held high.
REQ-026 Simultaneous out_ready and new grant: outgoing word delivered and new word loaded in the same edge, no bubble.
REQ-027 mode or select change takes effect on the cycle it is presented; an already-registered word is unaffected.
REQ-028 Only one input channel SHALL be considered; deasserting in_valid without in_ready is permitted and drops no state.

Reset
REQ-029 reset low SHALL asynchronously force out_valid = 0, out_data = 0, out_src = 0, ptr = NUM_IN-1 (first round-robin priority channel 0).
REQ-030 While reset is low all in_ready SHALL be 0; a word registered before reset is discarded.
REQ-031 First grant evaluation occurs on the first rising edge after reset deasserts.

Verification
REQ-032 Fixed mode: mode=0, select=2, in_valid=4'b1111, channel 2 word 32'hCAFE_0002, out_ready=1 -> in_ready=4'b0100; next cycle out_data=32'hCAFE_0002, out_src=2, out_valid=1.
REQ-033 Round-robin fairness: mode=1, in_valid=4'b1111 continuously, out_ready=1 after reset -> out_src sequence 0,1,2,3,0,1 on consecutive cycles.
REQ-034 Backpressure: out_valid=1, out_ready=0 for 3 cycles with all inputs valid -> in_ready=0, out_data and out_src stable, ptr unchanged; on out_ready=1 next source is ptr+1.
REQ-035 Sparse requests: mode=1, ptr=1, in_valid=4'b0001 -> grant channel 0 (wrap-around); then in_valid=4'b1001 -> grant channel 3.
REQ-036 Invalid select: NUM_IN=3, SEL_W=2, mode=0, select=3, all valid -> in_ready=0, out_valid falls to 0 after one edge with out_ready=1.
REQ-037 Reset mid-operation: out_valid=1 holding 32'h1234_5678, reset low between edges -> out_valid=0, out_data=0 immediately; after release with mode=1, first grant to channel 0.
